data_memory_responder: RTL and testbench

- Responder end of the execute-stage memory bus: accepts load/store requests from the load/store logic and services them against an internal word-organised synchronous data RAM.
- Does byte-lane extraction for loads and read-modify-write merging for sub-word stores.
- Reports misaligned, out-of-range and zero-width requests as errors.
- Sits between the execute unit and data storage; a single outstanding request at a time.

---
 rtl/data_memory_responder_if.sv | 23 ++
 rtl/data_memory_responder.sv | 75 +++++++
 tb/tb_data_memory_responder.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/data_memory_responder_if.sv
// data_memory_responder_if: execute-stage memory bus between load/store logic and the data memory responder
interface data_memory_responder_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_write;
  logic [1:0]            req_width;
  logic [ADDR_WIDTH-1:0] req_address;
  logic [DATA_WIDTH-1:0] req_write_data;
  logic                  rsp_valid;
  logic [DATA_WIDTH-1:0] rsp_read_data;
  logic                  rsp_error;
  modport master (
    output req_valid, req_write, req_width, req_address, req_write_data,
    input  req_ready, rsp_valid, rsp_read_data, rsp_error
  );
  modport slave (
    input  req_valid, req_write, req_width, req_address, req_write_data,
    output req_ready, rsp_valid, rsp_read_data, rsp_error
  );
endinterface

// File: rtl/data_memory_responder.sv
// data_memory_responder: services one load/store at a time against a word-organised synchronous RAM
module data_memory_responder #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int WORDS      = 1024
) (
  input logic clk,
  input logic rst_n,
  data_memory_responder_if.slave bus
);
  localparam int IW = $clog2(WORDS);
  localparam logic [1:0] IDLE = 2'd0, READ = 2'd1, MERGE = 2'd2, RESP = 2'd3;
  logic [1:0]            state, state_next;
  logic [DATA_WIDTH-1:0] mem [WORDS];
  logic [DATA_WIDTH-1:0] rdata, wdata_q, rsp_data, shifted, loaded, wshift, merged, ram_wd;
  logic [IW-1:0]         idx, idx_q, ram_addr;
  logic [1:0]            lane_q, width_q;
  logic [3:0]            be;
  logic                  accept, err, err_q, word_store, ram_we;
  assign accept     = bus.req_valid && bus.req_ready;
  assign idx        = bus.req_address[IW+1:2];
  assign err        = bus.req_width == 2'd0 ||
                      (bus.req_width == 2'd2 && bus.req_address[0]) ||
                      (bus.req_width == 2'd3 && bus.req_address[1:0] != 2'd0) ||
                      |bus.req_address[ADDR_WIDTH-1:IW+2];
  assign word_store = bus.req_write && bus.req_width == 2'd3;
  assign ram_we     = rst_n && ((state == IDLE && accept && !err && word_store) || state == MERGE);
  assign ram_addr   = state == MERGE ? idx_q : idx;
  assign ram_wd     = state == MERGE ? merged : bus.req_write_data;
  assign shifted    = rdata >> {lane_q, 3'b000};
  assign loaded     = width_q == 2'd1 ? DATA_WIDTH'(shifted[7:0]) :
                      width_q == 2'd2 ? DATA_WIDTH'(shifted[15:0]) : shifted;
  assign wshift     = wdata_q << {lane_q, 3'b000};
  assign be         = width_q == 2'd1 ? 4'b0001 << lane_q :
                      width_q == 2'd2 ? 4'b0011 << lane_q : 4'b1111;
  assign bus.req_ready     = state == IDLE;
  assign bus.rsp_valid     = state == RESP;
  assign bus.rsp_read_data = rsp_data;
  assign bus.rsp_error     = err_q;
  // overlay the addressed store lanes onto the word read back from RAM
  always_comb begin
    merged = rdata;
    for (int b = 0; b < 4; b++) merged[8*b +: 8] = be[b] ? wshift[8*b +: 8] : rdata[8*b +: 8];
  end
  // next state: errors and word stores respond directly, loads and sub-word stores take a RAM read first
  always_comb begin
    state_next = state == IDLE ? (accept ? (err || word_store ? RESP : bus.req_write ? MERGE : READ) : IDLE) :
                 state == RESP ? IDLE : RESP;
  end
  // single-port RAM, read-first, no reset on contents
  always_ff @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_wd;
    rdata <= mem[ram_addr];
  end
  // control state, latched request fields and registered response
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      idx_q    <= '0;
      lane_q   <= '0;
      width_q  <= '0;
      wdata_q  <= '0;
      err_q    <= 1'b0;
      rsp_data <= '0;
    end else begin
      state    <= state_next;
      idx_q    <= accept ? idx : idx_q;
      lane_q   <= accept ? bus.req_address[1:0] : lane_q;
      width_q  <= accept ? bus.req_width : width_q;
      wdata_q  <= accept ? bus.req_write_data : wdata_q;
      err_q    <= accept ? err : state == RESP ? 1'b0 : err_q;
      rsp_data <= state == READ ? loaded : state == RESP ? '0 : rsp_data;
    end
  end
endmodule

// File: tb/tb_data_memory_responder.sv
// tb_data_memory_responder: scoreboard bench for the data memory responder
module tb_data_memory_responder;
  typedef struct { int cyc; logic err; logic [31:0] data; } exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   fails = 0;
  exp_t q[$];
  exp_t e;
  logic [31:0] model [int];
  data_memory_responder_if bus ();
  data_memory_responder dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  // response monitor: pops the scoreboard on every response, checks idle outputs are zero otherwise
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.rsp_valid) begin
        checks++;
        if (q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_rsp: got err=%0b data=%h at cycle %0d, required no response", bus.rsp_error, bus.rsp_read_data, cyc);
        end else begin
          e = q.pop_front();
          if (bus.rsp_error !== e.err || bus.rsp_read_data !== e.data || cyc !== e.cyc) begin
            fails++;
            $display("FAIL rsp: got err=%0b data=%h cycle=%0d, required err=%0b data=%h cycle=%0d", bus.rsp_error, bus.rsp_read_data, cyc, e.err, e.data, e.cyc);
          end
        end
      end else begin
        checks++;
        if (bus.rsp_error !== 1'b0 || bus.rsp_read_data !== 32'h0) begin
          fails++;
          $display("FAIL idle_outputs: got err=%0b data=%h, required 0 0", bus.rsp_error, bus.rsp_read_data);
        end
      end
    end
  end
  task automatic issue(input logic w, input logic [1:0] wd, input logic [31:0] a, input logic [31:0] d, input bit track);
    int n, wi, sh;
    logic er;
    logic [31:0] m, old, rd;
    @(negedge clk);
    bus.req_write = w; bus.req_width = wd; bus.req_address = a; bus.req_write_data = d; bus.req_valid = 1'b1;
    n = 0;
    while (!bus.req_ready && n < 20) begin @(negedge clk); n++; end
    if (!bus.req_ready) begin
      checks++; fails++;
      $display("FAIL accept_timeout: req_ready=%0b, required 1", bus.req_ready);
      bus.req_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    if (track) begin
      er = wd == 2'd0 || (wd == 2'd2 && a[0]) || (wd == 2'd3 && a[1:0] != 2'd0) || a >= 32'h1000;
      m  = wd == 2'd1 ? 32'hFF : wd == 2'd2 ? 32'hFFFF : 32'hFFFF_FFFF;
      wi = int'(a[11:2]);
      sh = 8 * int'(a[1:0]);
      old = model.exists(wi) ? model[wi] : 32'h0;
      rd = 32'h0;
      if (!er && w) model[wi] = (old & ~(m << sh)) | ((d & m) << sh);
      if (!er && !w) rd = (old >> sh) & m;
      q.push_back('{cyc + ((er || (w && wd == 2'd3)) ? 0 : 1), er, rd});
    end
  endtask
  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 50) begin @(negedge clk); n++; end
    checks++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d responses outstanding, required 0", q.size());
      q.delete();
    end
  endtask
  task automatic test_reset();
    bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_width = 2'd0; bus.req_address = '0; bus.req_write_data = '0;
    repeat (2) @(negedge clk);
    checks++;
    if (bus.req_ready !== 1'b1 || bus.rsp_valid !== 1'b0 || bus.rsp_read_data !== 32'h0 || bus.rsp_error !== 1'b0) begin
      fails++;
      $display("FAIL reset: got ready=%0b valid=%0b data=%h err=%0b, required 1 0 0 0", bus.req_ready, bus.rsp_valid, bus.rsp_read_data, bus.rsp_error);
    end
    rst_n = 1'b1;
  endtask
  task automatic test_word();
    issue(1'b1, 2'd3, 32'h10, 32'hDEAD_BEEF, 1'b1);
    issue(1'b0, 2'd3, 32'h10, 32'h0, 1'b1);
    drain();
  endtask
  task automatic test_rmw();
    issue(1'b1, 2'd3, 32'h20, 32'h1122_3344, 1'b1);
    issue(1'b1, 2'd1, 32'h22, 32'hFFFF_FFAA, 1'b1);
    issue(1'b0, 2'd3, 32'h20, 32'h0, 1'b1);
    issue(1'b0, 2'd1, 32'h23, 32'h0, 1'b1);
    issue(1'b1, 2'd1, 32'h21, 32'h0000_0077, 1'b1);
    issue(1'b0, 2'd3, 32'h20, 32'h0, 1'b1);
    drain();
    checks++;
    if (model[8] !== 32'h11AA_7744) begin
      fails++;
      $display("FAIL rmw_model: got %h, required 11aa7744", model[8]);
    end
  endtask
  task automatic test_half();
    issue(1'b1, 2'd3, 32'h30, 32'h0, 1'b1);
    issue(1'b1, 2'd2, 32'h32, 32'h1234_BEEF, 1'b1);
    issue(1'b0, 2'd2, 32'h32, 32'h0, 1'b1);
    issue(1'b0, 2'd3, 32'h30, 32'h0, 1'b1);
    issue(1'b0, 2'd2, 32'h30, 32'h0, 1'b1);
    issue(1'b0, 2'd1, 32'h33, 32'h0, 1'b1);
    drain();
  endtask
  task automatic test_errors();
    issue(1'b1, 2'd3, 32'h0, 32'hCAFE_F00D, 1'b1);
    issue(1'b0, 2'd2, 32'h31, 32'h0, 1'b1);
    issue(1'b1, 2'd3, 32'h1002, 32'h1234_5678, 1'b1);
    issue(1'b1, 2'd2, 32'h1, 32'hFFFF, 1'b1);
    issue(1'b0, 2'd0, 32'h10, 32'h0, 1'b1);
    issue(1'b1, 2'd0, 32'h10, 32'h0, 1'b1);
    issue(1'b0, 2'd3, 32'h1000, 32'h0, 1'b1);
    issue(1'b1, 2'd1, 32'h1000, 32'hAB, 1'b1);
    issue(1'b1, 2'd3, 32'hFFFF_FFFC, 32'hAB, 1'b1);
    issue(1'b0, 2'd3, 32'h0, 32'h0, 1'b1);
    issue(1'b0, 2'd3, 32'h10, 32'h0, 1'b1);
    drain();
  endtask
  task automatic test_back_to_back();
    logic [31:0] addrs [3];
    int acc [3];
    int n;
    addrs = '{32'h10, 32'h20, 32'h30};
    @(negedge clk);
    bus.req_write = 1'b0; bus.req_width = 2'd3; bus.req_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.req_address = addrs[i];
      n = 0;
      while (!bus.req_ready && n < 20) begin @(negedge clk); n++; end
      if (!bus.req_ready) begin
        checks++; fails++;
        $display("FAIL b2b_timeout: req_ready=%0b, required 1", bus.req_ready);
        bus.req_valid = 1'b0;
        return;
      end
      @(posedge clk); #1;
      acc[i] = cyc;
      if (i == 2) bus.req_valid = 1'b0;
      q.push_back('{cyc + 1, 1'b0, model[int'(addrs[i][11:2])]});
      @(negedge clk);
      checks++;
      if (bus.req_ready !== 1'b0) begin fails++; $display("FAIL ready_read: got %0b, required 0", bus.req_ready); end
      @(negedge clk);
      checks++;
      if (bus.req_ready !== 1'b0) begin fails++; $display("FAIL ready_resp: got %0b, required 0", bus.req_ready); end
      if (i > 0) begin
        checks++;
        if (acc[i] - acc[i-1] !== 3) begin fails++; $display("FAIL b2b_spacing: got %0d, required 3", acc[i] - acc[i-1]); end
      end
    end
    drain();
  endtask
  task automatic test_reset_mid_merge();
    issue(1'b1, 2'd3, 32'h40, 32'h5555_5555, 1'b1);
    drain();
    issue(1'b1, 2'd1, 32'h40, 32'hAA, 1'b0);
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
        fails++;
        $display("FAIL reset_mid_merge: got valid=%0b ready=%0b, required 0 1", bus.rsp_valid, bus.req_ready);
      end
    end
    rst_n = 1'b1;
    issue(1'b0, 2'd3, 32'h40, 32'h0, 1'b1);
    drain();
  endtask
  initial begin
    test_reset();
    test_word();
    test_rmw();
    test_half();
    test_errors();
    test_back_to_back();
    test_reset_mid_merge();
    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
